// File: rtl/bus_to_reg_bank.sv
// Bus-to-register-bank transfer unit: a word captured from the shared bus is
// written byte-wise into one of four registers through an IDLE/WRITE/ACK handshake.
module bus_to_reg_bank #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] FROM_BUS,
  input  logic [1:0]  DST_SEL,
  input  logic [1:0]  BE,
  input  logic        LOAD,
  output logic [15:0] R0,
  output logic [15:0] R1,
  output logic [15:0] R2,
  output logic [15:0] R3,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] regs_q [4];
  logic [15:0] regs_d [4];
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    be_d    = be_q;
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (state_q)
      IDLE: begin
        if (LOAD) begin
          hold_d  = FROM_BUS;
          sel_d   = DST_SEL;
          be_d    = BE;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (be_q[0]) regs_d[sel_q][7:0]  = hold_q[7:0];
        if (be_q[1]) regs_d[sel_q][15:8] = hold_q[15:8];
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      // The unused encoding falls back to IDLE without touching the bank.
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WRITE) || (state_d == ACK);
    done_d = (state_d == ACK);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= 16'h0000;
      sel_q   <= 2'b00;
      be_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign R0   = regs_q[0];
  assign R1   = regs_q[1];
  assign R2   = regs_q[2];
  assign R3   = regs_q[3];
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_bus_to_reg_bank.sv
// Directed, table-driven bench for bus_to_reg_bank: byte-enabled transfers,
// input changes while busy, back-to-back loads and reset in the middle of a write.
module tb_bus_to_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] from_bus;
  logic [1:0]  dst_sel;
  logic [1:0]  be;
  logic        load;
  logic [15:0] r0, r1, r2, r3;
  logic        busy, done;

  int num_compared   = 0;
  int num_mismatched = 0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  sel;
    logic [1:0]  be;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic [15:0] exp3;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  bus_to_reg_bank #(.RESET_VAL(16'h0000)) dut (
    .CLK      (clk),
    .RST      (rst),
    .FROM_BUS (from_bus),
    .DST_SEL  (dst_sel),
    .BE       (be),
    .LOAD     (load),
    .R0       (r0),
    .R1       (r1),
    .R2       (r2),
    .R3       (r3),
    .BUSY     (busy),
    .DONE     (done)
  );

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    num_compared++;
    if (act !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    check_output({name, " R0"}, r0, e0);
    check_output({name, " R1"}, r1, e1);
    check_output({name, " R2"}, r2, e2);
    check_output({name, " R3"}, r3, e3);
  endtask

  // One transfer; while busy the bus inputs are scrambled and LOAD is raised
  // during WRITE, none of which may disturb the transfer in flight.
  task automatic apply_stimulus(input string name, input logic [15:0] data,
                                input logic [1:0] sel, input logic [1:0] b);
    @(negedge clk);
    load = 1'b1; from_bus = data; dst_sel = sel; be = b;
    @(negedge clk);
    check_output({name, " WRITE busy"}, {15'd0, busy}, 16'd1);
    check_output({name, " WRITE done"}, {15'd0, done}, 16'd0);
    load = 1'b1; from_bus = 16'hBEEF; dst_sel = ~sel; be = 2'b11;
    @(negedge clk);
    check_output({name, " ACK busy"}, {15'd0, busy}, 16'd1);
    check_output({name, " ACK done"}, {15'd0, done}, 16'd1);
    load = 1'b0;
    @(negedge clk);
    check_output({name, " IDLE busy"}, {15'd0, busy}, 16'd0);
    check_output({name, " IDLE done"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 2'b10, 2'b11, 16'h0000, 16'h0000, 16'hA5C3, 16'h0000};
    vecs[1] = '{16'h1234, 2'b01, 2'b11, 16'h0000, 16'h1234, 16'hA5C3, 16'h0000};
    vecs[2] = '{16'hFFEE, 2'b01, 2'b01, 16'h0000, 16'h12EE, 16'hA5C3, 16'h0000};
    vecs[3] = '{16'hFFEE, 2'b01, 2'b10, 16'h0000, 16'hFFEE, 16'hA5C3, 16'h0000};
    vecs[4] = '{16'hDEAD, 2'b00, 2'b00, 16'h0000, 16'hFFEE, 16'hA5C3, 16'h0000};
    vecs[5] = '{16'h0001, 2'b11, 2'b11, 16'h0000, 16'hFFEE, 16'hA5C3, 16'h0001};
    vecs[6] = '{16'h7788, 2'b00, 2'b10, 16'h7700, 16'hFFEE, 16'hA5C3, 16'h0001};
    vecs[7] = '{16'h1357, 2'b11, 2'b01, 16'h7700, 16'hFFEE, 16'hA5C3, 16'h0057};

    load = 1'b0; from_bus = 16'h0000; dst_sel = 2'b00; be = 2'b00;

    #1;
    check_regs("in reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check_output("in reset busy", {15'd0, busy}, 16'd0);
    check_output("in reset done", {15'd0, done}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_regs("idle no load", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check_output("idle busy", {15'd0, busy}, 16'd0);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].sel, vecs[i].be);
      check_regs($sformatf("vec%0d", i), vecs[i].exp0, vecs[i].exp1, vecs[i].exp2, vecs[i].exp3);
    end

    // LOAD held high: a new transfer every third cycle.
    @(negedge clk);
    load = 1'b1; be = 2'b11;
    for (int k = 0; k < 3; k++) begin
      dst_sel  = k[1:0];
      from_bus = 16'h0011 * 16'(k + 1);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check_output($sformatf("stream t%0d c%0d busy", k, c), {15'd0, busy}, (c < 2) ? 16'd1 : 16'd0);
        check_output($sformatf("stream t%0d c%0d done", k, c), {15'd0, done}, (c == 1) ? 16'd1 : 16'd0);
      end
    end
    load = 1'b0;
    @(negedge clk);
    check_regs("stream", 16'h0011, 16'h0022, 16'h0033, 16'h0057);

    // Reset arriving mid-cycle while WRITE is pending.
    load = 1'b1; from_bus = 16'h5555; dst_sel = 2'b00; be = 2'b11;
    @(negedge clk);
    load = 1'b0;
    check_output("pre-reset busy", {15'd0, busy}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check_regs("async reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check_output("async reset busy", {15'd0, busy}, 16'd0);
    check_output("async reset done", {15'd0, done}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output($sformatf("post-reset c%0d done", c), {15'd0, done}, 16'd0);
      check_output($sformatf("post-reset c%0d busy", c), {15'd0, busy}, 16'd0);
      check_output($sformatf("post-reset c%0d R0", c), r0, 16'h0000);
    end

    apply_stimulus("after reset", 16'h0F0F, 2'b00, 2'b11);
    check_regs("after reset", 16'h0F0F, 16'h0000, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
